// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, none/even/odd/mark parity,
// one or two stop bits, bit timing from an external oversample strobe.
module uart_tx_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 s_tick,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_in,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 tx_out
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE) + 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_en;
    logic                  par_bit;
    logic                  stop2_q;
    logic                  bit_end;

    // A bit period closes on the OVERSAMPLE-th tick seen since the bit began.
    assign bit_end  = s_tick && (tick_cnt == TICK_LAST);
    assign tx_ready = (state == StIdle);

    // Frame sequencer; every output except tx_ready is a flop.
    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            state    <= StIdle;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Overrun: a request while a frame is in flight is dropped and flagged.
            err  <= tx_valid && (state != StIdle);
            // The tick on the accepting edge is not counted (counter only runs off IDLE).
            if ((state != StIdle) && s_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    tx_out <= 1'b1;
                    if (tx_valid) begin
                        shreg    <= tx_in;
                        par_en   <= (parity_mode != 2'b00);
                        par_bit  <= (parity_mode == 2'b01) ? ^tx_in :
                                    (parity_mode == 2'b10) ? ~^tx_in : 1'b1;
                        stop2_q  <= stop2;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx_out <= shreg[0];
                        shreg  <= shreg >> 1;
                        state  <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (par_en) begin
                                tx_out <= par_bit;
                                state  <= StParity;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= StStop;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        tx_out <= 1'b1;
                        state  <= StStop;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        // bit_cnt enters STOP at zero and marks the first of two stop bits.
                        if (stop2_q && (bit_cnt == '0)) begin
                            bit_cnt <= BIT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= StIdle;
                        end
                    end
                end
                default: begin
                    state  <= StIdle;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: two instances (8 bits / x16 and 7 bits / x8), a
// tick-counting line model and per-cycle immediate assertions.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       valid;
    logic       sel;
    logic [7:0] din;
    logic [1:0] pm;
    logic       st2;

    logic ready0, busy0, done0, err0, tx0;
    logic ready1, busy1, done1, err1, tx1;
    logic obs_ready, obs_busy, obs_done, obs_err, obs_tx;

    // Reference model state: frame as a list of line levels, ticks since acceptance.
    logic frame[$];
    bit   m_busy;
    int   t;
    int   m_o;
    logic exp_tx, exp_done, exp_err;

    int   n_asserts = 0;
    int   n_fails = 0;
    int   cyc = 0;
    int   tick_period;
    int   phase;
    bit   toggle;
    bit   capturing;
    logic [9:0] cap;
    bit   prev_busy;
    int   start_cyc;
    int   last_len;
    int   exp_len;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut0 (
        .clk(clk), .rstN(rst), .s_tick(s_tick), .tx_valid(valid && !sel),
        .tx_ready(ready0), .tx_in(din), .parity_mode(pm), .stop2(st2),
        .busy(busy0), .done(done0), .err(err0), .tx_out(tx0)
    );

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut1 (
        .clk(clk), .rstN(rst), .s_tick(s_tick), .tx_valid(valid && sel),
        .tx_ready(ready1), .tx_in(din[6:0]), .parity_mode(pm), .stop2(st2),
        .busy(busy1), .done(done1), .err(err1), .tx_out(tx1)
    );

    assign obs_ready = sel ? ready1 : ready0;
    assign obs_busy  = sel ? busy1  : busy0;
    assign obs_done  = sel ? done1  : done0;
    assign obs_err   = sel ? err1   : err0;
    assign obs_tx    = sel ? tx1    : tx0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        t        = 0;
        exp_tx   = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Line level = frame[ticks / OVERSAMPLE] until all bit periods have elapsed.
    task automatic model_edge();
        logic [7:0] d;
        int nb;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            exp_err = valid && m_busy;
            if (!m_busy) begin
                if (valid) begin
                    nb  = sel ? 7 : 8;
                    m_o = sel ? 8 : 16;
                    d   = sel ? {1'b0, din[6:0]} : din;
                    frame.delete();
                    frame.push_back(1'b0);
                    for (int i = 0; i < nb; i++) frame.push_back(d[i]);
                    if (pm == 2'd1) frame.push_back(^d);
                    else if (pm == 2'd2) frame.push_back(~^d);
                    else if (pm == 2'd3) frame.push_back(1'b1);
                    frame.push_back(1'b1);
                    if (st2) frame.push_back(1'b1);
                    m_busy = 1'b1;
                    t = 0;
                end
            end else if (s_tick) begin
                t++;
                if (t == frame.size() * m_o) begin
                    m_busy   = 1'b0;
                    exp_done = 1'b1;
                end
            end
            exp_tx = m_busy ? frame[t / m_o] : 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_tx_out"}, obs_tx, exp_tx);
        check({tag, "_busy"}, obs_busy, m_busy);
        check({tag, "_ready"}, obs_ready, !m_busy);
        check({tag, "_done"}, obs_done, exp_done);
        check({tag, "_err"}, obs_err, exp_err);
    endtask

    // Measurements taken from the DUT outputs only.
    task automatic track();
        if (obs_busy && !prev_busy) start_cyc = cyc;
        if (obs_done) last_len = cyc - start_cyc;
        if (capturing && obs_busy && ((cyc - start_cyc) % 16 == 8)) cap = {cap[8:0], obs_tx};
        prev_busy = obs_busy;
    endtask

    task automatic step();
        @(negedge clk);
        if (toggle && m_busy) begin
            din = 8'($urandom);
            pm  = 2'($urandom);
            st2 = 1'($urandom);
        end
        s_tick = (phase == 0);
        phase  = (phase + 1 >= tick_period) ? 0 : phase + 1;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all("cyc");
        track();
    endtask

    task automatic finish_frame(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            step();
            n++;
        end
        check("frame_timeout", (n < budget), 1);
    endtask

    task automatic send_one();
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; sel = 1'b0; din = '0; pm = '0; st2 = 1'b0;
        s_tick = 1'b0; tick_period = 1; phase = 0; toggle = 1'b0; capturing = 1'b0;
        cap = '0; prev_busy = 1'b0; start_cyc = 0; last_len = 0;
        model_reset();
        #1;
        check_all("reset");
        step();
        step();
        rst = 1'b0;

        // 0xA5, no parity, one stop bit, tick every clk.
        din = 8'hA5; pm = 2'd0; st2 = 1'b0; capturing = 1'b1; cap = '0;
        send_one();
        finish_frame(400);
        capturing = 1'b0;
        check("a5_bits", cap, 10'b0101001011);
        check("a5_len", last_len, 160);
        step();

        // Two stop bits on an all-zero payload.
        din = 8'h00; st2 = 1'b1;
        send_one();
        finish_frame(400);
        check("stop2_len", last_len, 176);
        step();

        // Request held through two frames while inputs churn.
        toggle = 1'b1;
        din = 8'($urandom); pm = 2'($urandom); st2 = 1'($urandom);
        valid = 1'b1;
        step();
        finish_frame(400);
        step();
        finish_frame(400);
        valid = 1'b0;
        toggle = 1'b0;
        step();

        // Reset during data bit 3, then an immediate new frame.
        din = 8'($urandom); pm = 2'd0; st2 = 1'b0;
        send_one();
        for (int n = 0; n < 200 && t < 70; n++) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        step();
        step();
        rst = 1'b0;
        din = 8'h3C; pm = 2'd2;
        send_one();
        finish_frame(400);
        step();

        // Random frames with varying tick rates.
        for (int k = 0; k < 6; k++) begin
            din = 8'($urandom); pm = 2'($urandom); st2 = 1'($urandom);
            tick_period = $urandom_range(1, 3);
            phase = $urandom_range(0, tick_period - 1);
            send_one();
            finish_frame(2000);
            step();
        end

        // Seven-bit instance: parity variants on 0x55.
        sel = 1'b1; tick_period = 1; phase = 0;
        din = 8'h55; st2 = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            pm = 2'(p);
            send_one();
            finish_frame(300);
            check("p7_len", last_len, 80);
            step();
        end

        // Tick every 5 clks, aligned with the accepting edge; inputs churn mid-frame.
        tick_period = 5;
        din = 8'($urandom); pm = 2'($urandom); st2 = 1'($urandom);
        exp_len = (1 + 7 + ((pm != 2'd0) ? 1 : 0) + (st2 ? 2 : 1)) * 40;
        phase = 0;
        toggle = 1'b1;
        send_one();
        finish_frame(1000);
        toggle = 1'b0;
        check("os8_len", last_len, exp_len);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, s_tick pulses per bit period; legal range 8..32.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rstN, input, 1, reset; asynchronous and active-high (asserted = 1) despite the name.
REQ-005 SHALL have port s_tick, input, 1, oversample strobe, one clk wide.
REQ-006 SHALL have port tx_valid, input, 1, frame request.
REQ-007 SHALL have port tx_ready, output, 1, high when a request can be accepted.
REQ-008 SHALL have port tx_in, input, DATA_BITS, payload; LSB transmitted first.
REQ-009 SHALL have port parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 mark (parity bit = 1).
REQ-010 SHALL have port stop2, input, 1, 0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port done, output, 1, one-cycle end-of-frame pulse.
REQ-013 SHALL have port err, output, 1, one-cycle overrun pulse.
REQ-014 SHALL have port tx_out, output, 1, registered serial line; idle high.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL drive tx_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a clk edge with tx_valid && tx_ready, latching tx_in, parity_mode and stop2 into internal registers.
- Later input changes SHALL NOT affect the frame in flight.
REQ-018 SHALL move to START on acceptance, with the tick counter and bit counter cleared.
- tx_out = 0 and busy = 1 from the next cycle.
REQ-019 SHALL end each bit period on the OVERSAMPLE-th s_tick counted since that bit began.
- Counter width: $clog2(OVERSAMPLE)+1 bits.
- Without s_tick, the FSM SHALL hold indefinitely.
REQ-020 SHALL transition START -> DATA at the end of the start bit.
REQ-021 SHALL, in DATA, drive the latched payload LSB-first, shifting once per bit.
- After DATA_BITS bits it SHALL go to PARITY if the latched parity_mode != 00, else to STOP.
REQ-022 SHALL, in PARITY, drive one bit:
- even: XOR of the payload.
- odd: inverted XOR of the payload.
- mark: 1.
- Then go to STOP.
REQ-023 SHALL, in STOP, drive tx_out = 1 for one bit period, or two bit periods if the latched stop2 = 1, then return to IDLE.
REQ-024 SHALL pulse done = 1 for exactly one clk, coincident with the first IDLE cycle after the last stop bit.
- busy SHALL fall in that same cycle.
REQ-025 SHALL pulse err = 1 for one clk for each cycle tx_valid = 1 while tx_ready = 0.
- The request SHALL be ignored; the current frame SHALL be unaffected.
REQ-026 SHALL accept a new request in the same cycle done is high.
- Minimum idle gap between frames: one clk.
REQ-027 SHALL make the frame length in bit periods equal to 1 + DATA_BITS + (parity ? 1 : 0) + (stop2 ? 2 : 1).
REQ-028 SHALL treat s_tick coincident with acceptance as not counting toward the start bit.
REQ-029 SHALL produce a glitch-free tx_out, driven directly from a flop.

Reset
REQ-030 SHALL, on rstN = 1, immediately force: state IDLE, counters 0, tx_out = 1, busy = 0, done = 0, err = 0, tx_ready = 1.
REQ-031 SHALL abort a frame in progress when reset is asserted mid-frame, with no done pulse; tx_out SHALL go high asynchronously.
REQ-032 SHALL accept a request on the first clk edge after rstN deasserts.

Verification
REQ-033 Default params, tx_in = 8'hA5, parity 00, stop2 = 0, s_tick every clk -> tx_out = 0,1,0,1,0,0,1,0,1,1 with each bit 16 clks; done after 160 ticks.
REQ-034 DATA_BITS = 7, tx_in = 7'h55, parity 01 -> parity bit 0; parity 10 -> 1; parity 11 -> 1; frame = 10 bit periods.
REQ-035 stop2 = 1, tx_in = 8'h00 -> tx_out high for 32 ticks after the 8 data zeros; busy high for 11 bit periods total.
REQ-036 tx_valid held high during a frame -> err pulses every busy cycle; the next frame starts in the done cycle; transmitted data is unchanged.
REQ-037 rstN pulsed during bit 3 of DATA -> tx_out = 1 and busy = 0 without a clk edge; no done; the next frame transmits correctly.
REQ-038 s_tick every 5 clks with OVERSAMPLE = 8 -> each bit lasts 40 clks; tx_in toggled mid-frame -> the transmitted payload equals the originally latched value.
